inst_fetch_queue: RTL and testbench

- Small instruction queue directly downstream of the fetch PC buffer stage.
- Each cycle it captures the (pc, inst) pair presented by fetch and holds it until decode accepts it.
- Decouples fetch from decode stalls and discards all speculative entries on a branch or pipeline flush.
- Fetch must hold its PC whenever full_o is high.

---
 rtl/inst_fetch_queue.sv | 152 +++++++++++++++
 tb/tb_inst_fetch_queue.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue
//
// Purpose:
//   Small circular instruction queue sitting between the fetch PC buffer stage
//   and decode. It captures each valid (pc, inst) pair from fetch and holds it
//   until decode accepts it. A branch redirect or pipeline flush discards every
//   queued (speculative) entry. Fetch must hold its PC while full_o is high.
//
// Configuration:
//   IFQ_BYPASS_EN - when defined, an empty queue forwards pc_i/inst_i straight
//                   to the head outputs in the same cycle (zero-latency
//                   fall-through). When undefined, the head outputs come only
//                   from registers and push-to-visible latency is one cycle.
//
// Ports:
//   clk            in   system clock, rising-edge active
//   rst            in   asynchronous active-low reset
//   pc_i           in   PC from the fetch buffer stage
//   pc_valid_i     in   pc_i/inst_i pair is valid
//   inst_i         in   instruction word matching pc_i
//   branch_flag_i  in   branch redirect; discards queue contents
//   flush_i        in   pipeline flush; discards queue contents
//   id_ready_i     in   decode accepts the head entry this cycle
//   full_o         out  queue full; fetch must stall
//   pc_o           out  PC of the head entry (zero when empty)
//   inst_o         out  instruction of the head entry (zero when empty)
//   inst_valid_o   out  head entry valid
//   count_o        out  occupancy, 0..DEPTH
//
// Handshake: an entry moves into the queue on a rising edge where pc_valid_i
// is high, full_o is low and no kill is present; the head leaves on a rising
// edge where inst_valid_o and id_ready_i are both high and no kill is present.
// -----------------------------------------------------------------------------
module inst_fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              pc_valid_i,
    input  logic [DATA_W-1:0] inst_i,
    input  logic              branch_flag_i,
    input  logic              flush_i,
    input  logic              id_ready_i,
    output logic              full_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [DATA_W-1:0] inst_o,
    output logic              inst_valid_o,
    output logic [PTR_W:0]    count_o
);

    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
    logic [DATA_W-1:0] inst_mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;

    logic kill;
    logic full;
    logic empty;
    logic push;
    logic pop;
`ifdef IFQ_BYPASS_EN
    logic bypass_hit;
    logic bypass_take;
`endif

    // Control decode
    always_comb begin
        kill  = branch_flag_i | flush_i;
        full  = (count_q == DEPTH_CNT);
        empty = (count_q == '0);
`ifdef IFQ_BYPASS_EN
        // An empty queue presents the incoming pair directly; if decode takes
        // it in the same cycle it never needs to be stored.
        bypass_hit  = empty & pc_valid_i & ~kill;
        bypass_take = bypass_hit & id_ready_i;
        push        = pc_valid_i & ~full & ~kill & ~bypass_take;
`else
        push        = pc_valid_i & ~full & ~kill;
`endif
        // Pop only ever drains stored entries; a bypassed entry is handled above.
        pop = ~empty & id_ready_i & ~kill;
    end

    // Next-state for pointers and occupancy. Kill wins over push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (kill) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the wrap.
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]   <= pc_i;
            inst_mem_q[wr_ptr_q] <= inst_i;
        end
    end

    // Head outputs read as zero when empty so stale storage never leaks out.
    always_comb begin
        pc_o         = '0;
        inst_o       = '0;
        inst_valid_o = 1'b0;
        if (!empty) begin
            pc_o         = pc_mem_q[rd_ptr_q];
            inst_o       = inst_mem_q[rd_ptr_q];
            inst_valid_o = 1'b1;
        end
`ifdef IFQ_BYPASS_EN
        else if (bypass_hit) begin
            pc_o         = pc_i;
            inst_o       = inst_i;
            inst_valid_o = 1'b1;
        end
`endif
    end

    assign full_o  = full;
    assign count_o = count_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_queue
//
// Directed bench for inst_fetch_queue. Every accepted entry that decode should
// eventually receive is pushed into exp_q when it is driven; a monitor running
// on the falling edge pops and compares whenever the queue hands the head to
// decode. Occupancy/flag checks are made directly against hand-derived values.
// -----------------------------------------------------------------------------
module tb_inst_fetch_queue;

    localparam int DEPTH  = 4;
    localparam int PTR_W  = 2;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] pc_i;
    logic              pc_valid_i;
    logic [DATA_W-1:0] inst_i;
    logic              branch_flag_i;
    logic              flush_i;
    logic              id_ready_i;
    logic              full_o;
    logic [ADDR_W-1:0] pc_o;
    logic [DATA_W-1:0] inst_o;
    logic              inst_valid_o;
    logic [PTR_W:0]    count_o;

    int n_vec;
    int n_fail;
    logic [ADDR_W+DATA_W-1:0] exp_q[$];

    inst_fetch_queue #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .pc_valid_i   (pc_valid_i),
        .inst_i       (inst_i),
        .branch_flag_i(branch_flag_i),
        .flush_i      (flush_i),
        .id_ready_i   (id_ready_i),
        .full_o       (full_o),
        .pc_o         (pc_o),
        .inst_o       (inst_o),
        .inst_valid_o (inst_valid_o),
        .count_o      (count_o)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Scoreboard monitor: a handoff to decode happens on the coming rising edge
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && inst_valid_o && id_ready_i && !branch_flag_i && !flush_i) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL deliver: unexpected entry pc %h inst %h", pc_o, inst_o);
            end else begin
                check("deliver", {32'h0, pc_o, inst_o} >> 0 == 0 ? 64'h0 : {pc_o, inst_o},
                      exp_q.pop_front());
            end
        end
    end

    // Driver: apply one cycle of inputs shortly after a rising edge and return
    // just after the following rising edge.
    task automatic cyc(input logic pv, input logic [31:0] pc, input logic [31:0] ins,
                       input logic br, input logic fl, input logic rdy);
        pc_valid_i    = pv;
        pc_i          = pc;
        inst_i        = ins;
        branch_flag_i = br;
        flush_i       = fl;
        id_ready_i    = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_entry(input logic [31:0] pc, input logic [31:0] ins);
        exp_q.push_back({pc, ins});
    endtask

    task automatic check_empty(input string tag);
        check({tag, "_count"}, 64'(count_o), 64'd0);
        check({tag, "_valid"}, 64'(inst_valid_o), 64'd0);
        check({tag, "_pc"}, 64'(pc_o), 64'd0);
        check({tag, "_inst"}, 64'(inst_o), 64'd0);
        check({tag, "_full"}, 64'(full_o), 64'd0);
    endtask

    logic [31:0] pc_tab   [5];
    logic [31:0] inst_tab [5];

    initial begin
        n_vec  = 0;
        n_fail = 0;
        rst           = 1'b0;
        pc_valid_i    = 1'b0;
        pc_i          = '0;
        inst_i        = '0;
        branch_flag_i = 1'b0;
        flush_i       = 1'b0;
        id_ready_i    = 1'b0;
        pc_tab   = '{32'h1c000000, 32'h1c000004, 32'h1c000008, 32'h1c00000c, 32'h1c000010};
        inst_tab = '{32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213, 32'h00500293};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_empty("in_reset");
        rst = 1'b1;
        cyc(0, 32'h0, 32'h0, 0, 0, 0);
        check_empty("after_reset");

        // 1: single push, visible one cycle later
        expect_entry(32'h1c000000, 32'h02800421);
        cyc(1, 32'h1c000000, 32'h02800421, 0, 0, 0);
        check("t1_valid", 64'(inst_valid_o), 64'd1);
        check("t1_pc", 64'(pc_o), 64'h1c000000);
        check("t1_inst", 64'(inst_o), 64'h02800421);
        check("t1_count", 64'(count_o), 64'd1);
        cyc(0, 32'h0, 32'h0, 0, 0, 1);
        check_empty("t1_drain");

        // 2: fill to full, dropped pushes, ordered drain
        for (int i = 0; i < 4; i++) begin
            expect_entry(pc_tab[i], inst_tab[i]);
            cyc(1, pc_tab[i], inst_tab[i], 0, 0, 0);
            check("t2_count", 64'(count_o), 64'(i + 1));
            check("t2_full", 64'(full_o), (i == 3) ? 64'd1 : 64'd0);
        end
        cyc(1, pc_tab[4], inst_tab[4], 0, 0, 0);
        check("t2_drop_count", 64'(count_o), 64'd4);
        check("t2_drop_head", 64'(pc_o), 64'h1c000000);
        // push while full is dropped even though decode pops this cycle
        cyc(1, pc_tab[4], inst_tab[4], 0, 0, 1);
        check("t2_pop_full_count", 64'(count_o), 64'd3);
        check("t2_pop_full_full", 64'(full_o), 64'd0);
        check("t2_pop_full_head", 64'(pc_o), 64'h1c000004);
        repeat (3) cyc(0, 32'h0, 32'h0, 0, 0, 1);
        check_empty("t2_drain");

        // 3: steady state, one in one out per cycle, pointers wrap
        expect_entry(32'h1c000200, 32'ha0000000);
        cyc(1, 32'h1c000200, 32'ha0000000, 0, 0, 0);
        check("t3_prime_count", 64'(count_o), 64'd1);
        for (int i = 1; i <= 10; i++) begin
            expect_entry(32'h1c000200 + 32'(4 * i), 32'ha0000000 + 32'(i));
            cyc(1, 32'h1c000200 + 32'(4 * i), 32'ha0000000 + 32'(i), 0, 0, 1);
            check("t3_count", 64'(count_o), 64'd1);
            check("t3_head", 64'(pc_o), 64'(32'h1c000200 + 32'(4 * i)));
        end
        cyc(0, 32'h0, 32'h0, 0, 0, 1);
        check_empty("t3_drain");

        // 4: branch kill with a simultaneous push and ready
        for (int i = 0; i < 3; i++) begin
            cyc(1, pc_tab[i], inst_tab[i], 0, 0, 0);
        end
        check("t4_fill_count", 64'(count_o), 64'd3);
        cyc(1, 32'h1c000020, 32'h00600313, 1, 0, 1);
        check_empty("t4_kill");
        expect_entry(32'h1c000100, 32'h00700393);
        cyc(1, 32'h1c000100, 32'h00700393, 0, 0, 0);
        check("t4_new_head_pc", 64'(pc_o), 64'h1c000100);
        check("t4_new_head_count", 64'(count_o), 64'd1);
        cyc(0, 32'h0, 32'h0, 0, 0, 1);
        // flush alone and both kill sources together behave the same
        cyc(1, pc_tab[0], inst_tab[0], 0, 0, 0);
        cyc(0, 32'h0, 32'h0, 0, 1, 1);
        check_empty("t4_flush");
        cyc(1, pc_tab[1], inst_tab[1], 0, 0, 0);
        cyc(1, pc_tab[2], inst_tab[2], 1, 1, 1);
        check_empty("t4_both");

        // 5: asynchronous reset between edges with two entries queued
        cyc(1, pc_tab[0], inst_tab[0], 0, 0, 0);
        cyc(1, pc_tab[1], inst_tab[1], 0, 0, 0);
        pc_valid_i = 1'b0;
        check("t5_before_count", 64'(count_o), 64'd2);
        #2;
        rst = 1'b0;
        #1;
        check_empty("t5_async");
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(0, 32'h0, 32'h0, 0, 0, 1);
        check_empty("t5_after");

`ifdef IFQ_BYPASS_EN
        // 6: zero-latency fall-through consumed in the same cycle
        expect_entry(32'h1c000040, 32'h00800413);
        pc_valid_i = 1'b1;
        pc_i       = 32'h1c000040;
        inst_i     = 32'h00800413;
        id_ready_i = 1'b1;
        #1;
        check("t6_bypass_pc", 64'(pc_o), 64'h1c000040);
        check("t6_bypass_valid", 64'(inst_valid_o), 64'd1);
        @(posedge clk);
        #1;
        pc_valid_i = 1'b0;
        #1;
        check("t6_count", 64'(count_o), 64'd0);
        check("t6_valid", 64'(inst_valid_o), 64'd0);
`endif

        // every expected delivery must have been observed
        cyc(0, 32'h0, 32'h0, 0, 0, 0);
        check("sb_leftover", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
